// File: rtl/nand_flash_responder.sv
// rtl/nand_flash_responder.sv - NAND flash device-side emulator backed by a small page array
module nand_flash_responder #(
    parameter int          PAGE_BYTES  = 64,
    parameter int          NUM_PAGES   = 4,
    parameter int          BUSY_CYCLES = 32,
    parameter logic [39:0] DEV_ID      = 40'hECF1009540
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nf_cle,
    input  logic       nf_ale,
    input  logic       nf_ce_n,
    input  logic       nf_re_n,
    input  logic       nf_we_n,
    input  logic [7:0] nf_io_in,
    output logic [7:0] nf_io_out,
    output logic       nf_io_oe,
    output logic       r,
    output logic [7:0] status
);
    // Column and page fields are taken straight from the low bits of one
    // address byte, so both PAGE_BYTES and NUM_PAGES must lie in 2..256.
    localparam int CW    = $clog2(PAGE_BYTES);
    localparam int PW    = $clog2(NUM_PAGES);
    localparam int BW    = $clog2(BUSY_CYCLES + 1);
    localparam int DEPTH = PAGE_BYTES * NUM_PAGES;

    localparam logic [7:0] CMD_READ     = 8'h00;
    localparam logic [7:0] CMD_READ_GO  = 8'h30;
    localparam logic [7:0] CMD_PROG     = 8'h80;
    localparam logic [7:0] CMD_PROG_GO  = 8'h10;
    localparam logic [7:0] CMD_ERASE    = 8'h60;
    localparam logic [7:0] CMD_ERASE_GO = 8'hD0;
    localparam logic [7:0] CMD_ID       = 8'h90;
    localparam logic [7:0] CMD_STATUS   = 8'h70;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    typedef enum logic [3:0] {
        IDLE, ADDR_READ, ADDR_PROG, PROG_IN, ADDR_ERASE, ID_WAIT,
        READ_BUSY, PROG_BUSY, ERASE_BUSY, READ_OUT, ID_OUT, STATUS_OUT
    } state_t;

    state_t        state, state_next;
    logic          we_q, re_q;
    logic [7:0]    io_q;
    logic          we_rise, re_fall, re_rise;
    logic          cmd_edge, addr_edge, data_edge;
    logic [BW-1:0] busy_cnt;
    logic          busy, busy_expire;
    logic          busy_read, read_resume;
    logic [CW-1:0] col;
    logic [PW-1:0] page;
    logic [2:0]    addr_cnt, id_ptr;
    logic [7:0]    mem [DEPTH];
    logic          out_state, busy_start, erase_now, prog_write, addr_write;
    logic [7:0]    id_byte;

    // Edges compare the live pin with its previous-cycle value; CE_n high masks them all.
    assign we_rise   = !nf_ce_n && !we_q && nf_we_n;
    assign re_fall   = !nf_ce_n && re_q && !nf_re_n;
    assign re_rise   = !nf_ce_n && !re_q && nf_re_n;
    assign cmd_edge  = we_rise && nf_cle && !nf_ale;
    assign addr_edge = we_rise && nf_ale && !nf_cle;
    assign data_edge = we_rise && !nf_cle && !nf_ale;

    assign busy        = (busy_cnt != '0);
    assign busy_expire = (busy_cnt == BW'(1));
    assign r           = !busy;
    assign status      = busy ? 8'h80 : 8'hC0;

    // Pin history; io_q keeps the bus value from the last cycle WE_n was low.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q <= 1'b1;
            re_q <= 1'b1;
            io_q <= 8'h00;
        end else begin
            we_q <= nf_we_n;
            re_q <= nf_re_n;
            if (!nf_we_n) io_q <= nf_io_in;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: busy expiry first, then a command edge may override it.
    always_comb begin
        state_next = state;
        if (busy_expire) begin
            if (state == READ_BUSY) state_next = READ_OUT;
            else if (state == PROG_BUSY || state == ERASE_BUSY) state_next = IDLE;
        end
        if (cmd_edge) begin
            if (io_q == CMD_RESET) begin
                state_next = IDLE;
            end else if (io_q == CMD_STATUS) begin
                state_next = STATUS_OUT;
            end else if (!busy) begin
                case (io_q)
                    CMD_READ:     state_next = read_resume ? READ_OUT : ADDR_READ;
                    CMD_PROG:     state_next = ADDR_PROG;
                    CMD_ERASE:    state_next = ADDR_ERASE;
                    CMD_ID:       state_next = ID_WAIT;
                    CMD_READ_GO:  state_next = (state == ADDR_READ)  ? READ_BUSY  : IDLE;
                    CMD_PROG_GO:  state_next = (state == PROG_IN)    ? PROG_BUSY  : IDLE;
                    CMD_ERASE_GO: state_next = (state == ADDR_ERASE) ? ERASE_BUSY : IDLE;
                    default:      state_next = IDLE;
                endcase
            end
        end else if (addr_edge && state == ID_WAIT) begin
            state_next = ID_OUT;
        end else if (data_edge && state == ADDR_PROG) begin
            state_next = PROG_IN;
        end
    end

    // Per-state controls for the datapath and the ID byte selected by the pointer.
    always_comb begin
        out_state  = (state == ID_OUT) || (state == STATUS_OUT) || (state == READ_OUT);
        busy_start = cmd_edge && !busy &&
                     (state_next == READ_BUSY || state_next == PROG_BUSY || state_next == ERASE_BUSY);
        erase_now  = busy_start && (state_next == ERASE_BUSY);
        prog_write = data_edge && (state == ADDR_PROG || state == PROG_IN);
        addr_write = addr_edge && (state == ADDR_READ || state == ADDR_PROG || state == ADDR_ERASE);
        case (id_ptr)
            3'd0:    id_byte = DEV_ID[39:32];
            3'd1:    id_byte = DEV_ID[31:24];
            3'd2:    id_byte = DEV_ID[23:16];
            3'd3:    id_byte = DEV_ID[15:8];
            3'd4:    id_byte = DEV_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    // Busy timer, address capture, output pointers and the registered bus driver.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt    <= '0;
            busy_read   <= 1'b0;
            read_resume <= 1'b0;
            col         <= '0;
            page        <= '0;
            addr_cnt    <= 3'd0;
            id_ptr      <= 3'd0;
            nf_io_out   <= 8'h00;
            nf_io_oe    <= 1'b0;
        end else begin
            if (cmd_edge && io_q == CMD_RESET) busy_cnt <= '0;
            else if (busy_start)               busy_cnt <= BW'(BUSY_CYCLES);
            else if (busy)                     busy_cnt <= busy_cnt - BW'(1);

            if (busy_start) busy_read <= (state_next == READ_BUSY);

            // A read that finishes while status is being polled is resumed by a bare 0x00.
            if (cmd_edge && io_q != CMD_STATUS)
                read_resume <= 1'b0;
            else if (busy_expire && busy_read && state_next != READ_OUT)
                read_resume <= 1'b1;

            if (cmd_edge && (state_next == ADDR_READ || state_next == ADDR_PROG ||
                             state_next == ADDR_ERASE))
                addr_cnt <= 3'd0;
            else if (addr_write && addr_cnt != 3'd5)
                addr_cnt <= addr_cnt + 3'd1;

            if (addr_write && state != ADDR_ERASE && addr_cnt == 3'd0)
                col <= io_q[CW-1:0];
            else if (prog_write || (re_rise && state == READ_OUT))
                col <= col + CW'(1);

            if (addr_write && ((state == ADDR_ERASE && addr_cnt == 3'd0) ||
                               (state != ADDR_ERASE && addr_cnt == 3'd2)))
                page <= io_q[PW-1:0];

            if (cmd_edge && state_next == ID_WAIT)
                id_ptr <= 3'd0;
            else if (re_rise && state == ID_OUT && id_ptr != 3'd5)
                id_ptr <= id_ptr + 3'd1;

            nf_io_oe <= !nf_ce_n && !nf_re_n && out_state;
            if (re_fall) begin
                case (state)
                    ID_OUT:     nf_io_out <= id_byte;
                    STATUS_OUT: nf_io_out <= status;
                    READ_OUT:   nf_io_out <= mem[{page, col}];
                    default:    nf_io_out <= nf_io_out;
                endcase
            end
        end
    end

    // Page array: erase sets the whole page, program can only clear bits.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (erase_now) begin
                for (int i = 0; i < PAGE_BYTES; i++) mem[{page, CW'(i)}] <= 8'hFF;
            end else if (prog_write) begin
                mem[{page, col}] <= mem[{page, col}] & io_q;
            end
        end
    end
endmodule

// File: tb/tb_nand_flash_responder.sv
// tb/tb_nand_flash_responder.sv - directed scoreboard bench for nand_flash_responder
module tb_nand_flash_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nf_cle = 1'b0;
    logic       nf_ale = 1'b0;
    logic       nf_ce_n = 1'b0;
    logic       nf_re_n = 1'b1;
    logic       nf_we_n = 1'b1;
    logic [7:0] nf_io_in = 8'h00;
    logic [7:0] nf_io_out;
    logic       nf_io_oe;
    logic       r;
    logic [7:0] status;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    nand_flash_responder dut (
        .clk      (clk),
        .rst      (rst),
        .nf_cle   (nf_cle),
        .nf_ale   (nf_ale),
        .nf_ce_n  (nf_ce_n),
        .nf_re_n  (nf_re_n),
        .nf_we_n  (nf_we_n),
        .nf_io_in (nf_io_in),
        .nf_io_out(nf_io_out),
        .nf_io_oe (nf_io_oe),
        .r        (r),
        .status   (status)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic c, input logic a, input logic [7:0] d);
        nf_cle   = c;
        nf_ale   = a;
        nf_io_in = d;
        nf_we_n  = 1'b0;
        @(negedge clk);
        nf_we_n  = 1'b1;
        @(negedge clk);
        nf_cle   = 1'b0;
        nf_ale   = 1'b0;
    endtask

    task automatic cmd(input logic [7:0] d);
        wr(1'b1, 1'b0, d);
    endtask

    task automatic adr(input logic [7:0] d);
        wr(1'b0, 1'b1, d);
    endtask

    task automatic dat(input logic [7:0] d);
        wr(1'b0, 1'b0, d);
    endtask

    task automatic addr5(input logic [7:0] col, input logic [7:0] row);
        adr(col);
        adr(8'h00);
        adr(row);
        adr(8'h00);
        adr(8'h00);
    endtask

    // One RE pulse: the expected byte is queued, then popped once the device drives it.
    task automatic rd_expect(input logic [7:0] e, input string tag);
        exp_q.push_back(e);
        nf_re_n = 1'b0;
        @(negedge clk);
        check({tag, " oe"}, nf_io_oe, 1'b1);
        check(tag, nf_io_out, exp_q.pop_front());
        nf_re_n = 1'b1;
        @(negedge clk);
        check({tag, " oe_off"}, nf_io_oe, 1'b0);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!r && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " ready"}, r, 1'b1);
    endtask

    // Call right after the confirm command returns: counts the cycles r is low.
    task automatic busy_len(input string tag);
        int n = 0;
        while (!r && n < 200) begin
            n++;
            @(negedge clk);
        end
        check({tag, " busy_len"}, n, 32);
    endtask

    task automatic erase_page(input logic [7:0] row);
        cmd(8'h60);
        adr(row);
        adr(8'h00);
        adr(8'h00);
        cmd(8'hD0);
        busy_len("erase");
    endtask

    task automatic read_start(input logic [7:0] col, input logic [7:0] row);
        cmd(8'h00);
        addr5(col, row);
        cmd(8'h30);
        busy_len("read");
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] id_exp [6];
        int j;
        id_exp = '{8'hEC, 8'hF1, 8'h00, 8'h95, 8'h40, 8'h00};

        tick(3);
        check("rst r", r, 1'b1);
        check("rst oe", nf_io_oe, 1'b0);
        check("rst io_out", nf_io_out, 8'h00);
        check("rst status", status, 8'hC0);
        rst = 1'b0;
        tick(1);

        cmd(8'h90);
        adr(8'h00);
        for (int k = 0; k < 6; k++) rd_expect(id_exp[k], "id");

        cmd(8'h30);
        check("oos 30 no busy", r, 1'b1);

        erase_page(8'h01);
        read_start(8'h00, 8'h01);
        for (int k = 0; k < 64; k++) rd_expect(8'hFF, "erased");

        cmd(8'h80);
        addr5(8'h00, 8'h01);
        dat(8'hA5);
        dat(8'h3C);
        cmd(8'h10);
        busy_len("prog1");

        cmd(8'h80);
        addr5(8'h00, 8'h01);
        dat(8'h0F);
        cmd(8'h10);
        cmd(8'h70);
        j = 3;
        for (int k = 0; k < 20; k++) begin
            check("poll r", r, (j > 32) ? 1'b1 : 1'b0);
            rd_expect((j <= 32) ? 8'h80 : 8'hC0, "poll status");
            j += 2;
        end

        read_start(8'h00, 8'h01);
        rd_expect(8'h05, "and col0");
        rd_expect(8'h3C, "and col1");
        rd_expect(8'hFF, "and col2");

        erase_page(8'h02);
        cmd(8'h80);
        addr5(8'd62, 8'h02);
        dat(8'h11);
        dat(8'h22);
        dat(8'h33);
        dat(8'h44);
        cmd(8'h10);
        wait_ready("wrap prog");
        read_start(8'd62, 8'h02);
        rd_expect(8'h11, "wrap c62");
        rd_expect(8'h22, "wrap c63");
        rd_expect(8'h33, "wrap c0");
        rd_expect(8'h44, "wrap c1");

        cmd(8'h00);
        addr5(8'h00, 8'h02);
        cmd(8'h30);
        cmd(8'h70);
        wait_ready("resume");
        rd_expect(8'hC0, "resume status");
        cmd(8'h00);
        rd_expect(8'h33, "resume c0");
        rd_expect(8'h44, "resume c1");

        nf_ce_n = 1'b1;
        nf_re_n = 1'b0;
        tick(2);
        check("ce block oe", nf_io_oe, 1'b0);
        nf_re_n = 1'b1;
        tick(1);
        nf_ce_n = 1'b0;
        tick(1);
        rd_expect(8'hFF, "ce no advance c2");

        cmd(8'h60);
        adr(8'h03);
        adr(8'h00);
        adr(8'h00);
        cmd(8'hD0);
        tick(5);
        check("abort busy", r, 1'b0);
        cmd(8'hFF);
        check("abort r", r, 1'b1);
        check("abort status", status, 8'hC0);
        cmd(8'h70);
        rd_expect(8'hC0, "abort status read");

        read_start(8'h00, 8'h01);
        rd_expect(8'h05, "pre rst c0");
        nf_re_n = 1'b0;
        tick(1);
        check("pre rst oe", nf_io_oe, 1'b1);
        rst = 1'b1;
        tick(1);
        check("mid rst oe", nf_io_oe, 1'b0);
        check("mid rst r", r, 1'b1);
        check("mid rst status", status, 8'hC0);
        check("mid rst io_out", nf_io_out, 8'h00);
        rst = 1'b0;
        nf_re_n = 1'b1;
        tick(2);

        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
